// File: rtl/interp_coord_gen.sv
// Raster coordinate generator: walks signed X/Y accumulators over a COLS x ROWS
// grid, presenting one point per VALID/READY handshake, with a DONE pulse per frame.
`timescale 1ns/1ps
module interp_coord_gen #(
  parameter int W  = 8,
  parameter int CW = 8
) (
  input  logic                CLK,
  input  logic                RST_ASYNC_N,
  input  logic                START,
  input  logic signed [W-1:0] STEP_X,
  input  logic signed [W-1:0] STEP_Y,
  input  logic [CW-1:0]       COLS,
  input  logic [CW-1:0]       ROWS,
  input  logic                READY,
  output logic                VALID,
  output logic signed [W-1:0] X_DATA,
  output logic                X_WRITE_EN,
  output logic signed [W-1:0] Y_DATA,
  output logic                Y_WRITE_EN,
  output logic                LINE_END,
  output logic                BUSY,
  output logic                DONE
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t              state, state_n;
  logic signed [W-1:0] step_x, step_x_n, step_y, step_y_n;
  logic [CW-1:0]       cols, cols_n, rows, rows_n;
  logic [CW-1:0]       col, col_n, row, row_n;
  logic signed [W-1:0] x_n, y_n;
  logic                valid_n, x_we_n, y_we_n, line_end_n, busy_n, done_n;
  logic                last_col, last_row;

  // Only meaningful in RUN, where cols and rows are both non-zero.
  assign last_col = (col == cols - CW'(1));
  assign last_row = (row == rows - CW'(1));

  always_comb begin
    state_n    = state;
    step_x_n   = step_x;
    step_y_n   = step_y;
    cols_n     = cols;
    rows_n     = rows;
    col_n      = col;
    row_n      = row;
    x_n        = X_DATA;
    y_n        = Y_DATA;
    valid_n    = VALID;
    x_we_n     = 1'b0;
    y_we_n     = 1'b0;
    line_end_n = LINE_END;
    busy_n     = BUSY;
    done_n     = 1'b0;

    unique case (state)
      IDLE: begin
        if (START) begin
          step_x_n = STEP_X;
          step_y_n = STEP_Y;
          cols_n   = COLS;
          rows_n   = ROWS;
          col_n    = '0;
          row_n    = '0;
          x_n      = '0;
          y_n      = '0;
          if (COLS == '0 || ROWS == '0) begin
            state_n = FIN;
            done_n  = 1'b1;
          end else begin
            state_n    = RUN;
            valid_n    = 1'b1;
            busy_n     = 1'b1;
            x_we_n     = 1'b1;
            y_we_n     = 1'b1;
            line_end_n = (COLS == CW'(1));
          end
        end
      end

      RUN: begin
        if (VALID && READY) begin
          if (!last_col) begin
            col_n      = col + CW'(1);
            x_n        = X_DATA + step_x;
            x_we_n     = 1'b1;
            line_end_n = (col + CW'(1) == cols - CW'(1));
          end else if (!last_row) begin
            col_n      = '0;
            row_n      = row + CW'(1);
            x_n        = '0;
            y_n        = Y_DATA + step_y;
            x_we_n     = 1'b1;
            y_we_n     = 1'b1;
            line_end_n = (cols == CW'(1));
          end else begin
            state_n    = FIN;
            valid_n    = 1'b0;
            busy_n     = 1'b0;
            line_end_n = 1'b0;
            done_n     = 1'b1;
          end
        end
      end

      FIN: begin
        state_n = IDLE;
      end

      default: begin
        state_n    = IDLE;
        valid_n    = 1'b0;
        busy_n     = 1'b0;
        line_end_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_ASYNC_N) begin
    if (!RST_ASYNC_N) begin
      state      <= IDLE;
      step_x     <= '0;
      step_y     <= '0;
      cols       <= '0;
      rows       <= '0;
      col        <= '0;
      row        <= '0;
      X_DATA     <= '0;
      Y_DATA     <= '0;
      VALID      <= 1'b0;
      X_WRITE_EN <= 1'b0;
      Y_WRITE_EN <= 1'b0;
      LINE_END   <= 1'b0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
    end else begin
      state      <= state_n;
      step_x     <= step_x_n;
      step_y     <= step_y_n;
      cols       <= cols_n;
      rows       <= rows_n;
      col        <= col_n;
      row        <= row_n;
      X_DATA     <= x_n;
      Y_DATA     <= y_n;
      VALID      <= valid_n;
      X_WRITE_EN <= x_we_n;
      Y_WRITE_EN <= y_we_n;
      LINE_END   <= line_end_n;
      BUSY       <= busy_n;
      DONE       <= done_n;
    end
  end

endmodule

// File: tb/tb_interp_coord_gen.sv
// Directed bench for interp_coord_gen: a reference walk of each frame fills a
// queue of expected points which are popped as the DUT presents them.
`timescale 1ns/1ps
module tb_interp_coord_gen;

  logic              CLK = 1'b0;
  logic              RST_ASYNC_N = 1'b0;
  logic              START = 1'b0;
  logic signed [7:0] STEP_X = '0, STEP_Y = '0;
  logic [7:0]        COLS = '0, ROWS = '0;
  logic              READY = 1'b0;
  logic              VALID, X_WRITE_EN, Y_WRITE_EN, LINE_END, BUSY, DONE;
  logic signed [7:0] X_DATA, Y_DATA;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic signed [7:0] x;
    logic signed [7:0] y;
    logic              ywe;
    logic              le;
  } pt_t;

  pt_t q[$];

  interp_coord_gen #(.W(8), .CW(8)) dut (
    .CLK(CLK), .RST_ASYNC_N(RST_ASYNC_N), .START(START),
    .STEP_X(STEP_X), .STEP_Y(STEP_Y), .COLS(COLS), .ROWS(ROWS),
    .READY(READY), .VALID(VALID), .X_DATA(X_DATA), .X_WRITE_EN(X_WRITE_EN),
    .Y_DATA(Y_DATA), .Y_WRITE_EN(Y_WRITE_EN), .LINE_END(LINE_END),
    .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Start a frame on the next edge and follow it to DONE. The point with
  // 1-based index stall_pt is held off for stall_len cycles; at index mid_pt a
  // START with a different step is driven while the frame is running.
  task automatic run_frame(input int cols, input int rows,
                           input logic signed [7:0] sx, input logic signed [7:0] sy,
                           input int stall_pt, input int stall_len, input int mid_pt);
    logic signed [7:0] ax, ay;
    int pidx, stalls, exp_done;
    logic first, seen_done;
    pt_t e;
    ay = '0;
    for (int r = 0; r < rows; r++) begin
      ax = '0;
      for (int c = 0; c < cols; c++) begin
        q.push_back('{x: ax, y: ay, ywe: (c == 0), le: (c == cols - 1)});
        ax = ax + sx;
      end
      ay = ay + sy;
    end
    exp_done = (cols * rows == 0) ? 1 : cols * rows + stall_len + 1;

    @(negedge CLK);
    START = 1'b1; STEP_X = sx; STEP_Y = sy;
    COLS = 8'(cols); ROWS = 8'(rows); READY = 1'b1;
    pidx = 1; stalls = 0; first = 1'b1; seen_done = 1'b0;
    for (int n = 1; n <= 200 && !seen_done; n++) begin
      @(negedge CLK);
      START = 1'b0;
      STEP_X = 8'($urandom);
      STEP_Y = 8'($urandom);
      if (DONE) begin
        seen_done = 1'b1;
        chk("done_cycle", n, exp_done);
        chk("done_no_valid", VALID, 1'b0);
        chk("done_busy", BUSY, 1'b0);
        chk("queue_drained", q.size(), 0);
      end else begin
        chk("valid_in_run", VALID, 1'b1);
        chk("busy_in_run", BUSY, 1'b1);
        if (VALID && q.size() != 0) begin
          e = q[0];
          chk("x_data", X_DATA, e.x);
          chk("y_data", Y_DATA, e.y);
          chk("line_end", LINE_END, e.le);
          chk("x_we", X_WRITE_EN, first);
          chk("y_we", Y_WRITE_EN, first & e.ywe);
          if (pidx == stall_pt && stalls < stall_len) begin
            READY = 1'b0; stalls++; first = 1'b0;
          end else begin
            READY = 1'b1; void'(q.pop_front()); pidx++; first = 1'b1;
          end
          if (pidx == mid_pt) begin
            START = 1'b1; STEP_X = 8'sd7;
          end
        end
      end
    end
    if (!seen_done) chk("done_timeout", 0, 1);
    @(negedge CLK);
    chk("done_one_cycle", DONE, 1'b0);
    chk("idle_after_done", BUSY | VALID, 1'b0);
    q.delete();
  endtask

  initial begin
    #12;
    chk("rst_outputs", {VALID, X_WRITE_EN, Y_WRITE_EN, LINE_END, BUSY, DONE, X_DATA, Y_DATA}, '0);
    @(negedge CLK);
    RST_ASYNC_N = 1'b1;

    // Basic 3x2 frame
    run_frame(3, 2, 8'sd5, 8'sd3, 0, 0, 0);
    // Same frame, point 2 (5,0) stalled 3 cycles
    run_frame(3, 2, 8'sd5, 8'sd3, 2, 3, 0);
    // Wrap: 0,100,-56 and 0,-128,0
    run_frame(3, 1, 8'sd100, 8'sd0, 0, 0, 0);
    run_frame(1, 3, 8'sd0, -8'sd128, 0, 0, 0);
    // Negative steps over a larger grid with a stall at a line end
    run_frame(4, 3, -8'sd9, -8'sd20, 4, 2, 0);
    // Degenerate frames
    run_frame(0, 4, 8'sd1, 8'sd1, 0, 0, 0);
    run_frame(4, 0, 8'sd1, 8'sd1, 0, 0, 0);
    // START while busy
    run_frame(3, 2, 8'sd5, 8'sd3, 0, 0, 3);

    // Reset mid-frame, asserted between edges
    @(negedge CLK);
    START = 1'b1; STEP_X = 8'sd3; STEP_Y = 8'sd2; COLS = 8'd4; ROWS = 8'd4; READY = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    chk("pre_reset_running", {BUSY, VALID, (X_DATA != 0)}, 3'b111);
    #2 RST_ASYNC_N = 1'b0;
    #1 chk("async_reset_outputs",
           {VALID, X_WRITE_EN, Y_WRITE_EN, LINE_END, BUSY, DONE, X_DATA, Y_DATA}, '0);
    repeat (2) @(negedge CLK);
    chk("no_done_in_reset", DONE, 1'b0);
    RST_ASYNC_N = 1'b1;
    @(negedge CLK);
    chk("idle_after_reset", {BUSY, VALID, DONE}, 3'b000);
    run_frame(2, 1, 8'sd1, 8'sd0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/interp_coord_gen.md
# interp_coord_gen

Raster coordinate generator for the interpolation datapath. It steps a signed horizontal and vertical accumulator across a COLS x ROWS output grid and emits one (X, Y) point per accepted VALID/READY handshake. It drives the write side of the X and Y coordinate registers through the X_WRITE_EN/X_DATA and Y_WRITE_EN/Y_DATA pairs. A single START pulse runs one full frame, which ends with a one-cycle DONE.

## Interface
- W, 8, coordinate width; signed two's complement.
- CW, 8, unsigned width of the column and row count inputs and internal counters.
- CLK  in  1  clock; all state updates on the rising edge.
- RST_ASYNC_N  in  1  asynchronous, active-low reset; one clock, no other reset.
- START  in  1  frame start; sampled only in IDLE.
- STEP_X  in  W  signed horizontal step; latched on accepted START.
- STEP_Y  in  W  signed vertical step; latched on accepted START.
- COLS  in  CW  points per line; latched on accepted START.
- ROWS  in  CW  lines per frame; latched on accepted START.
- READY  in  1  downstream accepts the current point.
- VALID  out  1  X_DATA/Y_DATA hold a point.
- X_DATA  out  W  current accumulated horizontal coordinate.
- X_WRITE_EN  out  1  high on the first cycle a new X value is presented.
- Y_DATA  out  W  current accumulated vertical coordinate.
- Y_WRITE_EN  out  1  high on the first cycle a new Y value is presented.
- LINE_END  out  1  current point is the last column of its line.
- BUSY  out  1  frame in progress.
- DONE  out  1  one-cycle pulse after the last point is accepted.

## Operation
- All outputs are registered.
- Reset value of every output is 0, and the FSM enters IDLE. Latched parameters, counters and accumulators are also cleared to 0.
- States are IDLE, RUN and FIN.
- IDLE with START=1:
  - Latch STEP_X, STEP_Y, COLS and ROWS; clear col, row, X and Y.
  - If COLS==0 or ROWS==0, go to FIN with no point emitted.
  - Otherwise go to RUN, presenting point (0,0) with X_WRITE_EN=Y_WRITE_EN=1.
- RUN accepts a point on any edge where VALID and READY are both high. On acceptance:
  - If col<COLS-1: col+1, X_DATA<=X_DATA+STEP_X, X_WRITE_EN=1, Y_WRITE_EN=0.
  - Else if row<ROWS-1: col<=0, row+1, X_DATA<=0, Y_DATA<=Y_DATA+STEP_Y, both write enables =1.
  - Else: go to FIN with VALID=0.
- FIN: DONE=1 and BUSY=0 for exactly one cycle, then IDLE.
- Stall (VALID=1, READY=0): X_DATA, Y_DATA, LINE_END and VALID are held. Both write enables drop to 0 after the first presentation cycle.
- LINE_END=1 exactly while the presented point has col==COLS-1.
- BUSY=1 in RUN only.
- START is ignored in RUN and FIN.
- Arithmetic: W-bit two's-complement addition that wraps modulo 2^W. There is no saturation and no overflow flag.
- Steps are frozen for the whole frame; changes on STEP_X/STEP_Y inputs mid-frame have no effect.
- Reset asserted mid-frame clears everything immediately. No DONE is produced, and the next START begins a fresh frame.

## Timing
- Edge k samples START=1 in IDLE.
  - Cycle k+1: VALID=1, BUSY=1, point (0,0), both write enables high.
  - Degenerate frame (COLS or ROWS = 0): cycle k+1 instead shows DONE=1 with VALID=0.
- Point latency: a new point appears one cycle after the acceptance edge. With READY held high, one point is presented per cycle.
- Frame latency: with READY=1 throughout, DONE is high at cycle k+COLS*ROWS+1. Each cycle READY is low inside RUN adds one cycle.
- The DONE cycle never overlaps VALID. A new START is accepted at the earliest on the cycle after DONE, in IDLE.
- READY is don't-care outside RUN.

## Test plan
- Basic 3x2 frame: COLS=3, ROWS=2, STEP_X=5, STEP_Y=3, READY=1.
  - X sequence 0,5,10,0,5,10; Y sequence 0,0,0,3,3,3.
  - LINE_END on points 3 and 6; Y_WRITE_EN on points 1 and 4 only.
  - DONE exactly 7 cycles after the START edge.
- Stall: same frame with READY low for 3 cycles while point (5,0) is presented.
  - X_DATA holds 5 and VALID holds 1 during the stall.
  - X_WRITE_EN is high only on the first of those cycles.
  - DONE is delayed to cycle 10.
- Wrap and negative steps:
  - STEP_X=100, COLS=3, ROWS=1 gives X sequence 0,100,-56.
  - STEP_Y=-128, ROWS=3, COLS=1 gives Y sequence 0,-128,0.
- Degenerate frames: COLS=0, ROWS=4 -> VALID never high, DONE=1 at cycle k+1, BUSY stays 0. Repeat with ROWS=0.
- START while busy: pulse START with STEP_X=7 mid-frame. The frame continues with the original step, and exactly one DONE is produced.
- Reset mid-frame: drop RST_ASYNC_N between clock edges during RUN.
  - All outputs go to 0 immediately, without waiting for an edge.
  - A following START with COLS=2, ROWS=1, STEP_X=1 yields 0,1 then DONE.
